// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch target buffer: 2-bit counter states and the table entry layout.
package cpu_consts;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_t;

    // Widest tag a table entry can hold; narrower tags are zero-extended into it.
    localparam int BP_TAG_W_MAX = 32;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [63:0]             target;
        bp_ctr_t                 ctr;
    } bp_entry_t;

    localparam bp_ctr_t BP_CTR_INIT = WEAK_NT;

    function automatic logic bp_ctr_taken(input bp_ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import cpu_consts::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        case (ctr)
            STRONG_NT: ctr_next = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_next = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_next = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_next = taken ? STRONG_T : WEAK_T;
            default:   ctr_next = BP_CTR_INIT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit counters; registered lookup, trained from execute.
// Optional macro BP_PERF_CNT_EN adds branch / mispredict counters with a synchronous clear.
module branch_predictor
    import cpu_consts::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_pc_i,
    input  logic        flush_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [63:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic        upd_is_b_type_i,
    input  logic [63:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [63:0] upd_target_i,
`ifdef BP_PERF_CNT_EN
    input  logic        upd_pred_taken_i,
    input  logic        perf_clr_i,
    output logic [31:0] br_count_o,
    output logic [31:0] mispred_count_o
`else
    input  logic        upd_pred_taken_i
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TOP_B = IDX_W + TAG_W + 2;

    bp_entry_t               tbl [ENTRIES];
    logic [IDX_W-1:0]        fetch_idx;
    logic [IDX_W-1:0]        upd_idx;
    logic [BP_TAG_W_MAX-1:0] fetch_tag;
    logic [BP_TAG_W_MAX-1:0] upd_tag;
    bp_entry_t               fetch_ent;
    bp_entry_t               upd_ent;
    bp_entry_t               upd_new;
    bp_ctr_t                 ctr_next;
    logic                    fetch_hit;
    logic                    fetch_take;
    logic                    upd_hit;
    logic                    upd_fire;
    logic                    lookup_live;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign fetch_tag = BP_TAG_W_MAX'(fetch_pc_i[TOP_B-1:IDX_W+2]);
    assign upd_idx   = upd_pc_i[IDX_W+1:2];
    assign upd_tag   = BP_TAG_W_MAX'(upd_pc_i[TOP_B-1:IDX_W+2]);

    // Lookup reads the table as it stood before this edge, so a same-cycle update is not bypassed.
    assign fetch_ent   = tbl[fetch_idx];
    assign fetch_hit   = fetch_ent.valid && (fetch_ent.tag == fetch_tag);
    assign lookup_live = fetch_valid_i & ~flush_i;
    assign fetch_take  = lookup_live & fetch_hit & bp_ctr_taken(fetch_ent.ctr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            pred_valid_o  <= lookup_live;
            pred_taken_o  <= fetch_take;
            pred_target_o <= fetch_take ? fetch_ent.target : '0;
        end
    end

    assign upd_fire = upd_valid_i & upd_is_b_type_i;
    assign upd_ent  = tbl[upd_idx];
    assign upd_hit  = upd_ent.valid && (upd_ent.tag == upd_tag);

    bp_sat_counter u_sat_counter (
        .ctr      (upd_ent.ctr),
        .taken    (upd_taken_i),
        .ctr_next (ctr_next)
    );

    always_comb begin
        upd_new = upd_ent;
        if (upd_hit) begin
            upd_new.ctr = ctr_next;
            if (upd_taken_i) upd_new.target = upd_target_i;
        end else begin
            // Miss or empty slot: the resident entry is simply replaced.
            upd_new.valid  = 1'b1;
            upd_new.tag    = upd_tag;
            upd_new.target = upd_target_i;
            upd_new.ctr    = upd_taken_i ? WEAK_T : WEAK_NT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_INIT};
            end
        end else if (upd_fire) begin
            tbl[upd_idx] <= upd_new;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else if (perf_clr_i) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else if (upd_fire) begin
            br_count_o <= br_count_o + 32'd1;
            if (upd_taken_i != upd_pred_taken_i) mispred_count_o <= mispred_count_o + 32'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i[63:TOP_B], fetch_pc_i[1:0], upd_pc_i[63:TOP_B], upd_pc_i[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i[63:TOP_B], fetch_pc_i[1:0], upd_pc_i[63:TOP_B], upd_pc_i[1:0],
                           upd_pred_taken_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + random bench for branch_predictor against an array-based reference of the BTB rules.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 12;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_valid_i;
    logic [63:0] fetch_pc_i;
    logic        flush_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [63:0] pred_target_o;
    logic        upd_valid_i;
    logic        upd_is_b_type_i;
    logic [63:0] upd_pc_i;
    logic        upd_taken_i;
    logic [63:0] upd_target_i;
    logic        upd_pred_taken_i;
`ifdef BP_PERF_CNT_EN
    logic        perf_clr_i;
    logic [31:0] br_count_o;
    logic [31:0] mispred_count_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference table: plain arrays, counter as an integer 0..3.
    bit          m_valid [ENTRIES];
    logic [63:0] m_tag   [ENTRIES];
    logic [63:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_br;
    int unsigned m_mis;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_pc_i       (fetch_pc_i),
        .flush_i          (flush_i),
        .pred_valid_o     (pred_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_is_b_type_i  (upd_is_b_type_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
`ifdef BP_PERF_CNT_EN
        .upd_pred_taken_i (upd_pred_taken_i),
        .perf_clr_i       (perf_clr_i),
        .br_count_o       (br_count_o),
        .mispred_count_o  (mispred_count_o)
`else
        .upd_pred_taken_i (upd_pred_taken_i)
`endif
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return (pc >> (2 + IDX_W)) % (64'd1 << TAG_W);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    // One clock: drive inputs, predict from the pre-edge model, train the model, check after the edge.
    task automatic cyc(input bit fv, input logic [63:0] pc, input bit fl, input bit uv, input bit ub,
                       input logic [63:0] upc, input bit ut, input logic [63:0] utgt, input bit upt,
                       input bit clr);
        bit          e_valid, e_taken;
        logic [63:0] e_tgt;
        int          li, ui;
        fetch_valid_i    = fv;
        fetch_pc_i       = pc;
        flush_i          = fl;
        upd_valid_i      = uv;
        upd_is_b_type_i  = ub;
        upd_pc_i         = upc;
        upd_taken_i      = ut;
        upd_target_i     = utgt;
        upd_pred_taken_i = upt;
`ifdef BP_PERF_CNT_EN
        perf_clr_i       = clr;
`endif
        li      = idx_of(pc);
        e_valid = fv && !fl;
        e_taken = e_valid && m_valid[li] && (m_tag[li] == tag_of(pc)) && (m_ctr[li] >= 2);
        e_tgt   = e_taken ? m_tgt[li] : 64'h0;
        if (uv && ub) begin
            ui = idx_of(upc);
            if (m_valid[ui] && m_tag[ui] == tag_of(upc)) begin
                m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                               : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
                if (ut) m_tgt[ui] = utgt;
            end else begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = tag_of(upc);
                m_tgt[ui]   = utgt;
                m_ctr[ui]   = ut ? 2 : 1;
            end
        end
        if (clr) begin
            m_br  = 0;
            m_mis = 0;
        end else if (uv && ub) begin
            m_br++;
            if (ut != upt) m_mis++;
        end
        @(posedge clk);
        #1;
        check("pred_valid", {63'd0, pred_valid_o}, {63'd0, e_valid});
        check("pred_taken", {63'd0, pred_taken_o}, {63'd0, e_taken});
        check("pred_target", pred_target_o, e_tgt);
`ifdef BP_PERF_CNT_EN
        check("br_count", {32'd0, br_count_o}, {32'd0, m_br});
        check("mispred_count", {32'd0, mispred_count_o}, {32'd0, m_mis});
`endif
    endtask

    task automatic lookup(input logic [63:0] pc);
        cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [63:0] pc, input bit t, input logic [63:0] tgt);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, pc, t, tgt, t, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        cyc_init();
        model_reset();
        #12;
        check("reset_valid", {63'd0, pred_valid_o}, 64'h0);
        check("reset_taken", {63'd0, pred_taken_o}, 64'h0);
        check("reset_target", pred_target_o, 64'h0);
        resetn = 1'b1;

        // Cold lookup, then allocate taken and hit.
        lookup(64'h1000);
        update(64'h1000, 1'b1, 64'h0F00);
        lookup(64'h1000);
        check("alloc_hit_taken", {63'd0, pred_taken_o}, 64'h1);
        check("alloc_hit_target", pred_target_o, 64'h0F00);

        // Saturate up, walk down to weak NT, then pin at strong NT.
        for (int i = 0; i < 3; i++) update(64'h1000, 1'b1, 64'h0F00);
        for (int i = 0; i < 2; i++) update(64'h1000, 1'b0, 64'h0);
        lookup(64'h1000);
        check("weak_nt_taken", {63'd0, pred_taken_o}, 64'h0);
        for (int i = 0; i < 2; i++) update(64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b1, 64'h0E00);
        lookup(64'h1000);
        check("floor_then_one_taken", {63'd0, pred_taken_o}, 64'h0);

        // Aliasing entry replaces the 0x1000 entry at the same index.
        update(64'h1100, 1'b1, 64'h2000);
        lookup(64'h1000);
        check("alias_miss", {63'd0, pred_taken_o}, 64'h0);
        lookup(64'h1100);
        check("alias_target", pred_target_o, 64'h2000);

        // Same-cycle lookup and first allocation: no bypass.
        cyc(1'b1, 64'h3008, 1'b0, 1'b1, 1'b1, 64'h3008, 1'b1, 64'h4444, 1'b0, 1'b0);
        check("same_cycle_first", {63'd0, pred_taken_o}, 64'h0);
        lookup(64'h3008);
        check("same_cycle_next", {63'd0, pred_taken_o}, 64'h1);

        // Flush kills the prediction; non-B-type update is ignored.
        cyc(1'b1, 64'h1100, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("flush_valid", {63'd0, pred_valid_o}, 64'h0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h5000, 1'b1, 64'h6000, 1'b1, 1'b0);
        lookup(64'h5000);

`ifdef BP_PERF_CNT_EN
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h7000, 1'b1, 64'h1, 1'b1, 1'b1);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h7000, 1'b1, 64'h1, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h7004, 1'b0, 64'h1, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h7008, 1'b0, 64'h1, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h700C, 1'b1, 64'h1, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h7010, 1'b0, 64'h1, 1'b0, 1'b0);
        check("perf_br5", {32'd0, br_count_o}, 64'd5);
        check("perf_mis2", {32'd0, mispred_count_o}, 64'd2);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
        check("perf_clr_br", {32'd0, br_count_o}, 64'd0);
`endif

        // Mid-operation asynchronous reset with a taken prediction on the outputs.
        update(64'h1100, 1'b1, 64'h2000);
        lookup(64'h1100);
        fetch_valid_i = 1'b1;
        upd_valid_i   = 1'b1;
        upd_is_b_type_i = 1'b1;
        resetn = 1'b0;
        #2;
        check("midreset_valid", {63'd0, pred_valid_o}, 64'h0);
        check("midreset_taken", {63'd0, pred_taken_o}, 64'h0);
        check("midreset_target", pred_target_o, 64'h0);
        model_reset();
        resetn = 1'b1;
        lookup(64'h1100);

        // Random traffic over a small PC pool so hits, aliases and ignored PC bits all occur.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] lpc, upc;
            lpc = {$urandom, 32'h0} | 64'h1000 | (64'($urandom_range(0, 7)) << 2)
                  | (64'($urandom_range(0, 3)) << 8) | 64'($urandom_range(0, 3));
            upc = {$urandom, 32'h0} | 64'h1000 | (64'($urandom_range(0, 7)) << 2)
                  | (64'($urandom_range(0, 3)) << 8) | 64'($urandom_range(0, 3));
            cyc(($urandom % 4) != 0, lpc, ($urandom % 8) == 0, $urandom % 2 == 1,
                ($urandom % 5) != 0, upc, $urandom % 2 == 1, {$urandom, $urandom},
                $urandom % 2 == 1, ($urandom % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    task automatic cyc_init();
        fetch_valid_i    = 1'b0;
        fetch_pc_i       = '0;
        flush_i          = 1'b0;
        upd_valid_i      = 1'b0;
        upd_is_b_type_i  = 1'b0;
        upd_pc_i         = '0;
        upd_taken_i      = 1'b0;
        upd_target_i     = '0;
        upd_pred_taken_i = 1'b0;
`ifdef BP_PERF_CNT_EN
        perf_clr_i       = 1'b0;
`endif
    endtask

endmodule
